markov_second_sampler: RTL

- Consumer of the second-order Markov transition table built by the merge stage.
- Holds the current context (prev2, prev1) and, per request, scans the table for entries matching that context.
- Draws the next note with probability proportional to each entry's count, using an internal LFSR.
- Emits the note and shifts it into the context history, so repeated requests generate a melody stream.

---
 rtl/markov_second_sampler_pkg.sv | 35 +++
 rtl/markov_lfsr.sv | 39 +++
 rtl/markov_second_sampler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/markov_second_sampler_pkg.sv
// rtl/markov_second_sampler_pkg.sv - shared widths, table entry layout, LFSR constants and FSM states
package markov_second_sampler_pkg;

  // Default widths, shared with the merge stage that builds the table
  localparam int NOTE_W_DEF = 7;
  localparam int CNT_W_DEF  = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int LFSR_W_DEF = 16;

  // LFSR never sits at zero; this value is used on reset and for a zero seed
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;

  // Sampler FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SUM  = 3'd1;
  localparam logic [2:0] ST_DRAW = 3'd2;
  localparam logic [2:0] ST_PICK = 3'd3;
  localparam logic [2:0] ST_EMIT = 3'd4;

  // Table entry layout {key_prev2, key_prev1, next_note, count}, count in the LSBs
  function automatic int note_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int key1_lsb(input int note_w, input int cnt_w);
    return cnt_w + note_w;
  endfunction

  function automatic int key2_lsb(input int note_w, input int cnt_w);
    return cnt_w + 2 * note_w;
  endfunction

endpackage

// File: rtl/markov_lfsr.sv
// rtl/markov_lfsr.sv - Fibonacci LFSR random source with seed load and single-step advance
module markov_lfsr
  import markov_second_sampler_pkg::*;
#(
  parameter int W = LFSR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic [W-1:0] value_o
);

  localparam logic [W-1:0] RESET_VAL = W'(LFSR_RESET);
  localparam logic [W-1:0] TAPS      = W'(LFSR_TAPS);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Load has priority; a zero seed is replaced so the register never locks up
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = (seed_i == '0) ? RESET_VAL : seed_i;
    end else if (step_i) begin
      value_d = {^(value_q & TAPS), value_q[W-1:1]};
    end
  end

  // LFSR state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= RESET_VAL;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/markov_second_sampler.sv
// rtl/markov_second_sampler.sv - second-order Markov note sampler; MARKOV_SAMPLER_RANDOM_FALLBACK_EN selects a random note on a miss
module markov_second_sampler
  import markov_second_sampler_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LFSR_W = LFSR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed,
  input  logic                      ctx_load,
  input  logic [NOTE_W-1:0]         ctx_prev2,
  input  logic [NOTE_W-1:0]         ctx_prev1,
  input  logic [ADDR_W:0]           list_len,
  input  logic                      start,
  output logic                      busy,
  output logic                      tbl_rd,
  output logic [ADDR_W-1:0]         tbl_addr,
  input  logic [3*NOTE_W+CNT_W-1:0] tbl_data,
  output logic                      done,
  output logic [NOTE_W-1:0]         note,
  output logic                      miss
);

  localparam int SUM_W  = CNT_W + ADDR_W;
  localparam int PROD_W = SUM_W + LFSR_W;
  localparam int NOTE_L = note_lsb(CNT_W);
  localparam int KEY1_L = key1_lsb(NOTE_W, CNT_W);
  localparam int KEY2_L = key2_lsb(NOTE_W, CNT_W);
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic [SUM_W-1:0]  total_q, total_d, run_q, run_d, thr_q, thr_d, run_sum;
  logic [NOTE_W-1:0] sel_q, sel_d, prev2_q, prev1_q, note_q, emit_note;
  logic              hit_q, hit_d, miss_q, done_q, lfsr_step;
  logic [LFSR_W-1:0] lfsr_val;
  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  ent_cnt;
  logic [NOTE_W-1:0] ent_note;
  logic              ent_match;

  markov_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (seed_load && (state_q == ST_IDLE)),
    .seed_i (seed),
    .step_i (lfsr_step),
    .value_o(lfsr_val)
  );

  assign ent_cnt   = tbl_data[CNT_W-1:0];
  assign ent_note  = tbl_data[NOTE_L +: NOTE_W];
  assign ent_match = (tbl_data[KEY2_L +: NOTE_W] == prev2_q) && (tbl_data[KEY1_L +: NOTE_W] == prev1_q);
  assign run_sum   = run_q + SUM_W'(ent_cnt);
  assign prod      = PROD_W'(lfsr_val) * PROD_W'(total_q);

  assign busy     = (state_q != ST_IDLE);
  assign tbl_rd   = ((state_q == ST_SUM) || (state_q == ST_PICK)) && (idx_q < len_q);
  assign tbl_addr = idx_q[ADDR_W-1:0];
  assign done     = done_q;
  assign note     = note_q;
  assign miss     = miss_q;

`ifdef MARKOV_SAMPLER_RANDOM_FALLBACK_EN
  logic [NOTE_W-1:0] rnd_q;
  // A miss emits the LFSR bits seen in DRAW; an empty list never steps, so the live value is used
  assign emit_note = hit_q ? sel_q : ((len_q == '0) ? lfsr_val[NOTE_W-1:0] : rnd_q);

  // Capture the random bits before DRAW advances the LFSR
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   rnd_q <= '0;
    else if (state_q == ST_DRAW) rnd_q <= lfsr_val[NOTE_W-1:0];
  end
`else
  assign emit_note = hit_q ? sel_q : prev1_q;
`endif

  // FSM: sum matching counts, draw a threshold, re-scan to pick the entry crossing it
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rd_vld_d  = 1'b0;
    total_d   = total_q;
    run_d     = run_q;
    thr_d     = thr_q;
    sel_d     = sel_q;
    hit_d     = hit_q;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = list_len;
          idx_d   = '0;
          total_d = '0;
          hit_d   = 1'b0;
          state_d = (list_len == '0) ? ST_EMIT : ST_SUM;
        end
      end
      ST_SUM: begin
        if (tbl_rd) idx_d = idx_q + IDX_ONE;
        rd_vld_d = tbl_rd;
        if (rd_vld_q && ent_match) total_d = total_q + SUM_W'(ent_cnt);
        if (idx_q == len_q) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        lfsr_step = 1'b1;
        if (total_q == '0) begin
          state_d = ST_EMIT;
        end else begin
          thr_d   = prod[PROD_W-1:LFSR_W];
          run_d   = '0;
          idx_d   = '0;
          state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        if (tbl_rd) idx_d = idx_q + IDX_ONE;
        rd_vld_d = tbl_rd;
        if (rd_vld_q && ent_match) begin
          run_d = run_sum;
          if ((ent_cnt != '0) && (run_sum > thr_q)) begin
            sel_d    = ent_note;
            hit_d    = 1'b1;
            rd_vld_d = 1'b0;
            state_d  = ST_EMIT;
          end
        end else if (!tbl_rd && !rd_vld_q) begin
          // Table exhausted without a pick (only if it changed mid-request): report a miss
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan/accumulator state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
      total_q  <= '0;
      run_q    <= '0;
      thr_q    <= '0;
      sel_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rd_vld_q <= rd_vld_d;
      total_q  <= total_d;
      run_q    <= run_d;
      thr_q    <= thr_d;
      sel_q    <= sel_d;
      hit_q    <= hit_d;
    end
  end

  // Result outputs and context history; history shifts as each note is emitted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      note_q  <= '0;
      miss_q  <= 1'b0;
      prev2_q <= '0;
      prev1_q <= '0;
    end else begin
      done_q <= (state_q == ST_EMIT);
      if (state_q == ST_EMIT) begin
        note_q  <= emit_note;
        miss_q  <= !hit_q;
        prev2_q <= prev1_q;
        prev1_q <= emit_note;
      end else if ((state_q == ST_IDLE) && ctx_load) begin
        prev2_q <= ctx_prev2;
        prev1_q <= ctx_prev1;
      end
    end
  end

endmodule
